// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared types and constants for the data-memory responder
package data_memory_responder_pkg;

    // Byte-address bits below the word index
    localparam int WORD_OFFSET = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_RANGE      = 2'd2,
        FAULT_CONFLICT   = 2'd3
    } fault_cause_t;

    // Index width that still works for a single-word memory
    function automatic int index_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/data_memory_responder_array.sv
// rtl/data_memory_responder_array.sv - single-port synchronous word RAM
module data_memory_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [DATA_WIDTH-1:0]  write_data,
    output logic [DATA_WIDTH-1:0]  read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Read-before-write single port; contents survive reset on purpose
    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[index] <= write_data;
        end
        read_data <= mem[index];
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - MEM-stage responder with wait states, ready handshake and fault reporting
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sig_enable_data_memory_read,
    input  logic                  sig_enable_data_memory_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  mem_fault
);

    localparam int         INDEX_WIDTH = index_width(DEPTH_WORDS);
    localparam int         WORD_WIDTH  = ADDR_WIDTH - WORD_OFFSET;
    localparam logic [3:0] WAIT_LAST   = 4'(WAIT_STATES - 1);

    state_t                 state;
    logic [3:0]             wait_count;
    logic                   op_read;
    logic                   op_write;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    fault_cause_t           cause_q;

    logic                   request;
    logic [WORD_WIDTH-1:0]  word_index;
    fault_cause_t           capture_cause;
    logic [INDEX_WIDTH-1:0] ram_index;
    logic                   ram_write;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    assign request    = sig_enable_data_memory_read | sig_enable_data_memory_write;
    assign word_index = address[ADDR_WIDTH-1:WORD_OFFSET];

    // Classify the incoming request; a conflict outranks address problems
    always_comb begin
        capture_cause = FAULT_NONE;
        if (sig_enable_data_memory_read && sig_enable_data_memory_write) begin
            capture_cause = FAULT_CONFLICT;
        end else if (address[WORD_OFFSET-1:0] != '0) begin
            capture_cause = FAULT_MISALIGNED;
        end else if (word_index >= WORD_WIDTH'(DEPTH_WORDS)) begin
            capture_cause = FAULT_RANGE;
        end
    end

    // In IDLE the RAM looks at the live address so a zero-wait read has data ready at RESP
    always_comb begin
        ram_index = index_q;
        if (state == ST_IDLE) begin
            ram_index = word_index[INDEX_WIDTH-1:0];
        end
    end

    // Reset is synchronous, so gating the write here lets reset abort an access in RESP
    assign ram_write = (state == ST_RESP) && op_write && (cause_q == FAULT_NONE) && !reset;

    data_memory_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_array (
        .clock        (clock),
        .write_enable (ram_write),
        .index        (ram_index),
        .write_data   (wdata_q),
        .read_data    (ram_rdata)
    );

    // Request FSM: capture, wait, respond once, then drain the held enable level
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_count <= '0;
            op_read    <= 1'b0;
            op_write   <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
            cause_q    <= FAULT_NONE;
            data_out   <= '0;
            mem_ready  <= 1'b0;
            mem_busy   <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        op_read    <= sig_enable_data_memory_read;
                        op_write   <= sig_enable_data_memory_write;
                        index_q    <= word_index[INDEX_WIDTH-1:0];
                        wdata_q    <= data_in;
                        cause_q    <= capture_cause;
                        mem_busy   <= 1'b1;
                        wait_count <= '0;
                        state      <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (wait_count == WAIT_LAST) begin
                        state <= ST_RESP;
                    end else begin
                        wait_count <= wait_count + 4'd1;
                    end
                end
                ST_RESP: begin
                    mem_ready  <= 1'b1;
                    mem_busy   <= 1'b0;
                    wait_count <= '0;
                    if (cause_q != FAULT_NONE) begin
                        mem_fault <= 1'b1;
                        if (op_read) begin
                            data_out <= '0;
                        end
                    end else if (op_read) begin
                        data_out <= ram_rdata;
                    end
                    state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!request) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
module tb_data_memory_responder;

    localparam int DEPTH = 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_addr, a_din, a_dout, b_addr, b_din, b_dout;
    logic        a_ready, a_busy, a_fault, b_ready, b_busy, b_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem   [2][DEPTH];
    bit          model_valid [2][DEPTH];
    logic [31:0] model_dout  [2];

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_a (
        .clock(clock), .reset(reset),
        .sig_enable_data_memory_read(a_rd), .sig_enable_data_memory_write(a_wr),
        .address(a_addr), .data_in(a_din), .data_out(a_dout),
        .mem_ready(a_ready), .mem_busy(a_busy), .mem_fault(a_fault)
    );

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
        .clock(clock), .reset(reset),
        .sig_enable_data_memory_read(b_rd), .sig_enable_data_memory_write(b_wr),
        .address(b_addr), .data_in(b_din), .data_out(b_dout),
        .mem_ready(b_ready), .mem_busy(b_busy), .mem_fault(b_fault)
    );

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    task automatic set_inputs(input int sel, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] din);
        if (sel == 0) begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_din = din;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_din = din;
        end
    endtask

    // Drive one request held for 'hold' edges and observe the outputs each cycle
    task automatic run_req(input int sel, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] din, input int hold,
                           output int ready_count, output int ready_cycle, output int busy_count,
                           output int fault_count, output logic [31:0] dout_at_ready,
                           output logic [31:0] dout_end);
        int budget;
        budget = hold + wait_of(sel) + 6;
        ready_count = 0; ready_cycle = -1; busy_count = 0; fault_count = 0;
        dout_at_ready = '0;
        @(negedge clock);
        set_inputs(sel, rd, wr, addr, din);
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clock);
            @(negedge clock);
            if ((sel == 0) ? a_ready : b_ready) begin
                if (ready_count == 0) begin
                    ready_cycle   = cyc;
                    dout_at_ready = (sel == 0) ? a_dout : b_dout;
                end
                ready_count++;
            end
            if ((sel == 0) ? a_busy : b_busy) busy_count++;
            if ((sel == 0) ? a_fault : b_fault) fault_count++;
            if (cyc == hold - 1) set_inputs(sel, 1'b0, 1'b0, addr, din);
        end
        dout_end = (sel == 0) ? a_dout : b_dout;
    endtask

    // Reference behaviour: what one request should do to memory and to data_out
    task automatic model_step(input int sel, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] din,
                              output bit exp_fault);
        int idx;
        exp_fault = (rd && wr) || (addr % 4 != 0) || ((addr / 4) >= DEPTH);
        if (exp_fault) begin
            if (rd) model_dout[sel] = '0;
        end else begin
            idx = int'(addr / 4);
            if (rd) begin
                model_dout[sel] = model_mem[sel][idx];
            end else begin
                model_mem[sel][idx]   = din;
                model_valid[sel][idx] = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_inputs(0, 1'b0, 1'b0, '0, '0);
        set_inputs(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (a_dout !== 32'h0) begin errors++; $display("FAIL reset_a_dout: got %h expected 0", a_dout); end
        checks++; if ({a_ready, a_busy, a_fault} !== 3'b000) begin errors++; $display("FAIL reset_a_flags: got %b expected 000", {a_ready, a_busy, a_fault}); end
        checks++; if (b_dout !== 32'h0) begin errors++; $display("FAIL reset_b_dout: got %h expected 0", b_dout); end
        checks++; if ({b_ready, b_busy, b_fault} !== 3'b000) begin errors++; $display("FAIL reset_b_flags: got %b expected 000", {b_ready, b_busy, b_fault}); end
        reset = 1'b0;
        model_dout[0] = '0;
        model_dout[1] = '0;
    endtask

    task automatic test_write_read;
        int rc, rcy, bc, fc; logic [31:0] dr, de; bit ef;
        run_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ef);
        checks++; if (rc !== 1) begin errors++; $display("FAIL wr_ready_count: got %0d expected 1", rc); end
        checks++; if (rcy !== 3) begin errors++; $display("FAIL wr_ready_cycle: got %0d expected 3", rcy); end
        checks++; if (bc !== 3) begin errors++; $display("FAIL wr_busy_cycles: got %0d expected 3", bc); end
        checks++; if (fc !== 0) begin errors++; $display("FAIL wr_fault: got %0d expected 0", fc); end
        checks++; if (de !== model_dout[0]) begin errors++; $display("FAIL wr_dout_unchanged: got %h expected %h", de, model_dout[0]); end
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b1, 1'b0, 32'h10, 32'h0, ef);
        checks++; if (rcy !== 3) begin errors++; $display("FAIL rd_ready_cycle: got %0d expected 3", rcy); end
        checks++; if (dr !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", dr); end
    endtask

    task automatic test_zero_wait_held;
        int rc, rcy, bc, fc; logic [31:0] dr, de; bit ef;
        run_req(1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1, rc, rcy, bc, fc, dr, de);
        model_step(1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, ef);
        checks++; if (rcy !== 1) begin errors++; $display("FAIL w0_wr_ready_cycle: got %0d expected 1", rcy); end
        run_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 5, rc, rcy, bc, fc, dr, de);
        model_step(1, 1'b1, 1'b0, 32'h10, 32'h0, ef);
        checks++; if (rc !== 1) begin errors++; $display("FAIL w0_held_ready_count: got %0d expected 1", rc); end
        checks++; if (rcy !== 1) begin errors++; $display("FAIL w0_rd_ready_cycle: got %0d expected 1", rcy); end
        checks++; if (bc !== 1) begin errors++; $display("FAIL w0_busy_cycles: got %0d expected 1", bc); end
        checks++; if (dr !== 32'hCAFEF00D) begin errors++; $display("FAIL w0_rd_data: got %h expected cafef00d", dr); end
    endtask

    task automatic test_misaligned;
        int rc, rcy, bc, fc; logic [31:0] dr, de; bit ef;
        run_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b1, 1'b0, 32'h13, 32'h0, ef);
        checks++; if (rcy !== 3) begin errors++; $display("FAIL mis_ready_cycle: got %0d expected 3", rcy); end
        checks++; if (fc !== 1) begin errors++; $display("FAIL mis_fault_count: got %0d expected 1", fc); end
        checks++; if (dr !== 32'h0) begin errors++; $display("FAIL mis_dout: got %h expected 0", dr); end
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b1, 1'b0, 32'h10, 32'h0, ef);
        checks++; if (dr !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_after_rd: got %h expected deadbeef", dr); end
    endtask

    task automatic test_range;
        int rc, rcy, bc, fc; logic [31:0] dr, de; bit ef;
        run_req(0, 1'b0, 1'b1, 32'h0, 32'h0BADC0DE, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b0, 1'b1, 32'h0, 32'h0BADC0DE, ef);
        run_req(0, 1'b0, 1'b1, 32'h400, 32'h55555555, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b0, 1'b1, 32'h400, 32'h55555555, ef);
        checks++; if (fc !== 1 || rc !== 1) begin errors++; $display("FAIL range_fault: got fault %0d ready %0d expected 1 1", fc, rc); end
        run_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b1, 1'b0, 32'h0, 32'h0, ef);
        checks++; if (dr !== 32'h0BADC0DE) begin errors++; $display("FAIL range_word0: got %h expected 0badc0de", dr); end
    endtask

    task automatic test_conflict;
        int rc, rcy, bc, fc; logic [31:0] dr, de; bit ef;
        run_req(0, 1'b1, 1'b1, 32'h10, 32'h11111111, 2, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b1, 1'b1, 32'h10, 32'h11111111, ef);
        checks++; if (fc !== 1) begin errors++; $display("FAIL conflict_fault: got %0d expected 1", fc); end
        checks++; if (dr !== 32'h0) begin errors++; $display("FAIL conflict_dout: got %h expected 0", dr); end
        run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b1, 1'b0, 32'h10, 32'h0, ef);
        checks++; if (dr !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_no_write: got %h expected deadbeef", dr); end
    endtask

    task automatic test_reset_mid_wait;
        int rc, rcy, bc, fc, late_ready; logic [31:0] dr, de; bit ef;
        run_req(0, 1'b0, 1'b1, 32'h20, 32'hA5A50020, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b0, 1'b1, 32'h20, 32'hA5A50020, ef);
        @(negedge clock);
        set_inputs(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        @(posedge clock);
        @(negedge clock);
        set_inputs(0, 1'b0, 1'b0, 32'h20, 32'h12345678);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_dout[0] = '0;
        model_dout[1] = '0;
        checks++; if ({a_ready, a_busy, a_fault} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {a_ready, a_busy, a_fault}); end
        checks++; if (a_dout !== 32'h0) begin errors++; $display("FAIL rst_dout: got %h expected 0", a_dout); end
        late_ready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (a_ready || a_busy) late_ready++;
        end
        checks++; if (late_ready !== 0) begin errors++; $display("FAIL rst_aborted: got %0d active cycles expected 0", late_ready); end
        run_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1, rc, rcy, bc, fc, dr, de);
        model_step(0, 1'b1, 1'b0, 32'h20, 32'h0, ef);
        checks++; if (rcy !== 3) begin errors++; $display("FAIL rst_next_latency: got %0d expected 3", rcy); end
        checks++; if (dr !== 32'hA5A50020) begin errors++; $display("FAIL rst_old_contents: got %h expected a5a50020", dr); end
    endtask

    task automatic test_random;
        int rc, rcy, bc, fc, sel, kind, idx, hold; logic [31:0] dr, de, addr, din; logic rd, wr; bit ef;
        for (int n = 0; n < 60; n++) begin
            sel  = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            idx  = int'($urandom_range(0, 31));
            hold = int'($urandom_range(1, 4));
            din  = $urandom;
            rd = 1'b0; wr = 1'b1; addr = 32'(idx * 4);
            if (kind >= 4 && kind <= 7 && model_valid[sel][idx]) begin
                rd = 1'b1; wr = 1'b0;
            end else if (kind == 8) begin
                rd = 1'($urandom_range(0, 1)); wr = ~rd; addr = addr | 32'($urandom_range(1, 3));
            end else if (kind == 9) begin
                if ($urandom_range(0, 1) == 0) begin
                    rd = 1'b1; wr = 1'b1;
                end else begin
                    rd = 1'($urandom_range(0, 1)); wr = ~rd;
                    addr = 32'((DEPTH + $urandom_range(0, 1000)) * 4);
                end
            end
            run_req(sel, rd, wr, addr, din, hold, rc, rcy, bc, fc, dr, de);
            model_step(sel, rd, wr, addr, din, ef);
            checks++; if (rc !== 1) begin errors++; $display("FAIL rand_ready_count[%0d]: got %0d expected 1", n, rc); end
            checks++; if (rcy !== wait_of(sel) + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, rcy, wait_of(sel) + 1); end
            checks++; if (bc !== wait_of(sel) + 1) begin errors++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", n, bc, wait_of(sel) + 1); end
            checks++; if (fc !== int'(ef)) begin errors++; $display("FAIL rand_fault[%0d]: got %0d expected %0d", n, fc, ef); end
            checks++; if (dr !== model_dout[sel]) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", n, dr, model_dout[sel]); end
            checks++; if (de !== model_dout[sel]) begin errors++; $display("FAIL rand_dout_hold[%0d]: got %h expected %h", n, de, model_dout[sel]); end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_valid[s][i] = 1'b0;
                model_mem[s][i]   = '0;
            end
        end
        test_reset;
        test_write_read;
        test_zero_wait_held;
        test_misaligned;
        test_range;
        test_conflict;
        test_reset_mid_wait;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the data-memory access issued by the multi-cycle control unit during the MEM stage.
- Samples the read/write enable levels and the ALU-computed address and store data.
- Performs a word access to an internal synchronous RAM after a configurable number of wait states, then returns a one-cycle completion pulse and registered load data to the datapath write-back mux.
- Gives the control unit a real ready handshake instead of a fixed one-cycle memory assumption.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 256, number of RAM words; legal word index 0..DEPTH_WORDS-1.
- WAIT_STATES, 2, cycles between request capture and completion (0..15).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- sig_enable_data_memory_read  input  1  load request level from the control unit.
- sig_enable_data_memory_write  input  1  store request level from the control unit.
- address  input  ADDR_WIDTH  byte address; must be word aligned.
- data_in  input  DATA_WIDTH  store data (Rb).
- data_out  output  DATA_WIDTH  registered load data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high from capture until completion.
- mem_fault  output  1  one-cycle pulse coincident with mem_ready on an illegal request.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high. Reset has priority over everything.
- Reset values:
  - data_out = 0, mem_ready = 0, mem_busy = 0, mem_fault = 0, state = IDLE, wait counter = 0.
  - RAM contents are NOT cleared by reset.
- FSM states:
  - IDLE: if read or write is high at an edge, capture op, address and data_in, set mem_busy = 1. Go to WAIT if WAIT_STATES > 0, else to RESP.
  - WAIT: count WAIT_STATES cycles, then go to RESP. Inputs are ignored in WAIT; captured values are used.
  - RESP: the access takes effect at this edge. A write updates RAM[word index]; a read loads data_out. mem_ready = 1 and mem_busy = 0 for exactly one cycle. Then go to DRAIN.
  - DRAIN: stay until both enables are low, then return to IDLE. This makes a level held high by the control unit count as one request only.
- Latency: a request sampled at edge N gives mem_ready high during cycle N+WAIT_STATES+1.
- Word index = address[ADDR_WIDTH-1:2].
- Fault conditions:
  - address[1:0] != 0;
  - word index >= DEPTH_WORDS;
  - both enables high at capture.
- On a fault:
  - no RAM write;
  - data_out is forced to 0 (fault on a read or on a both-high request);
  - mem_fault pulses together with mem_ready;
  - same timing as a legal access.
- data_out holds its last value except on a read completion or a fault.
- A write completion leaves data_out unchanged.
- Reset during WAIT or RESP aborts the access: no RAM write occurs, and the FSM returns to IDLE the next cycle with all outputs at reset values.
- A new request arriving in the same cycle that DRAIN exits is not captured. Capture only happens from IDLE.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, WAIT, RESP, DRAIN, 2 bits);
  - the word-offset constant (2);
  - a fault-cause enum (none, misaligned, range, conflict) for debug and coverage.
- Sub-module data_memory_array:
  - single-port synchronous RAM;
  - parameters DATA_WIDTH and DEPTH_WORDS;
  - ports clock, write enable, index, write data, read data.
  - The responder drives its write enable only in RESP.

Test Plan:
- WAIT_STATES=2: write 0xDEADBEEF to address 0x10 (held 4 cycles) -> mem_busy for 3 cycles, mem_ready pulse at N+3, exactly one pulse. Then read 0x10 -> data_out = 0xDEADBEEF at N+3.
- WAIT_STATES=0: read address 0x10 -> mem_ready in cycle N+1, data_out valid in the same cycle. Enable held 5 cycles -> no second ready pulse.
- Read address 0x13 -> mem_fault = 1 and mem_ready = 1 at N+3, data_out = 0. A subsequent read of 0x10 still returns the prior value.
- DEPTH_WORDS=256: write to address 0x400 -> mem_fault pulse, and RAM word 0 is unchanged when read back.
- Read and write enables both high -> fault pulse, no write, data_out = 0.
- Write 0x12345678 to 0x20, with reset asserted for 1 cycle at N+2 (mid-WAIT) -> no mem_ready, outputs zero, and a later read of 0x20 returns the old contents. Issue a read after reset releases -> normal latency.
